// File: rtl/mxint_acc_pkg.sv
// Shared state encoding and width helpers for the MXINT aligned accumulator.
package mxint_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        BIAS  = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    function automatic int unsigned cnt_width(input int unsigned max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // Headroom for MAX_DEPTH data blocks plus one bias block.
    function automatic int unsigned out_man_width(input int unsigned man_w, input int unsigned max_depth);
        return man_w + cnt_width(max_depth);
    endfunction

endpackage

// File: rtl/mxint_align_add.sv
// Per-lane exponent-aligned add: the operand with the smaller exponent is shifted
// right (toward -inf) before summing; a first beat simply loads the operand.
module mxint_align_add #(
    parameter int unsigned IN_MAN_WIDTH  = 16,
    parameter int unsigned OUT_MAN_WIDTH = 21,
    parameter int unsigned IN_EXP_WIDTH  = 4,
    parameter int unsigned BLOCK_SIZE    = 4
) (
    input  logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0] i_acc_man,
    input  logic [IN_EXP_WIDTH-1:0]             i_acc_exp,
    input  logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0]  i_op_man,
    input  logic [IN_EXP_WIDTH-1:0]             i_op_exp,
    input  logic                                i_first,
    output logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0] o_sum_man,
    output logic [IN_EXP_WIDTH-1:0]             o_sum_exp
);

    localparam int unsigned OW = OUT_MAN_WIDTH;
    localparam int unsigned IW = IN_MAN_WIDTH;

    logic                    w_in_gt;
    logic [IN_EXP_WIDTH-1:0] w_d;
    logic                    w_far;

    assign w_in_gt   = i_op_exp > i_acc_exp;
    assign w_d       = w_in_gt ? (i_op_exp - i_acc_exp) : (i_acc_exp - i_op_exp);
    assign w_far     = 32'(w_d) >= OW;
    assign o_sum_exp = (i_first || w_in_gt) ? i_op_exp : i_acc_exp;

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
        logic signed [OW-1:0] w_acc;
        logic signed [OW-1:0] w_op;
        logic signed [OW-1:0] w_acc_asr;
        logic signed [OW-1:0] w_op_asr;
        logic signed [OW-1:0] w_acc_fill;
        logic signed [OW-1:0] w_op_fill;
        logic signed [OW-1:0] w_acc_sh;
        logic signed [OW-1:0] w_op_sh;
        logic signed [OW-1:0] w_sum;

        assign w_acc      = $signed(i_acc_man[g*OW +: OW]);
        assign w_op       = OW'($signed(i_op_man[g*IW +: IW]));
        assign w_acc_asr  = w_acc >>> w_d;
        assign w_op_asr   = w_op >>> w_d;
        assign w_acc_fill = {OW{w_acc[OW-1]}};
        assign w_op_fill  = {OW{w_op[OW-1]}};
        // Shifting past the full width leaves only the sign.
        assign w_acc_sh   = w_far ? w_acc_fill : w_acc_asr;
        assign w_op_sh    = w_far ? w_op_fill : w_op_asr;

        always_comb begin
            w_sum = w_acc + w_op_sh;
            if (i_first) begin
                w_sum = w_op;
            end else if (w_in_gt) begin
                w_sum = w_acc_sh + w_op;
            end
        end

        assign o_sum_man[g*OW +: OW] = w_sum;
    end

endmodule

// File: rtl/mxint_align_accumulator.sv
// Streaming MXINT block accumulator: sums cfg_depth data blocks aligned to the
// running max exponent, optionally adds one bias block, then holds the result.
module mxint_align_accumulator
    import mxint_acc_pkg::*;
#(
    parameter int unsigned IN_MAN_WIDTH  = 16,
    parameter int unsigned IN_EXP_WIDTH  = 4,
    parameter int unsigned BLOCK_SIZE    = 4,
    parameter int unsigned MAX_DEPTH     = 16,
    parameter int unsigned OUT_MAN_WIDTH = out_man_width(IN_MAN_WIDTH, MAX_DEPTH),
    parameter int unsigned CNT_WIDTH     = cnt_width(MAX_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CNT_WIDTH-1:0]                cfg_depth,
    input  logic                                cfg_bias_en,
    input  logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0]  mdata_in_0,
    input  logic [IN_EXP_WIDTH-1:0]             edata_in_0,
    input  logic                                data_in_0_valid,
    output logic                                data_in_0_ready,
    input  logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0]  mbias,
    input  logic [IN_EXP_WIDTH-1:0]             ebias,
    input  logic                                bias_valid,
    output logic                                bias_ready,
    output logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0] mdata_out_0,
    output logic [IN_EXP_WIDTH-1:0]             edata_out_0,
    output logic                                data_out_0_valid,
    input  logic                                data_out_0_ready,
    output logic [CNT_WIDTH-1:0]                accum_count
);

    acc_state_t                         r_state;
    logic [CNT_WIDTH-1:0]               r_count;
    logic [CNT_WIDTH-1:0]               r_depth;
    logic                               r_bias_en;
    logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0] r_acc;
    logic [IN_EXP_WIDTH-1:0]            r_exp;
    logic                               r_out_valid;
    logic                               r_bias_ready;

    logic                               w_data_hs;
    logic                               w_bias_hs;
    logic                               w_out_hs;
    logic                               w_first;
    logic [CNT_WIDTH-1:0]               w_depth_clamped;
    logic [CNT_WIDTH-1:0]               w_eff_depth;
    logic                               w_eff_bias;
    logic [CNT_WIDTH-1:0]               w_next_count;
    acc_state_t                         w_beat_next;
    logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0] w_op_man;
    logic [IN_EXP_WIDTH-1:0]            w_op_exp;
    logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0] w_sum_man;
    logic [IN_EXP_WIDTH-1:0]            w_sum_exp;

    // In HOLD a new beat is only taken alongside the output handshake.
    assign data_in_0_ready  = (r_state == ACCUM) || ((r_state == HOLD) && data_out_0_ready);
    assign bias_ready       = r_bias_ready;
    assign data_out_0_valid = r_out_valid;
    assign mdata_out_0      = r_acc;
    assign edata_out_0      = r_exp;
    assign accum_count      = r_count;

    assign w_data_hs = data_in_0_valid && data_in_0_ready;
    assign w_bias_hs = bias_valid && r_bias_ready;
    assign w_out_hs  = r_out_valid && data_out_0_ready;

    always_comb begin
        w_depth_clamped = cfg_depth;
        if (cfg_depth == '0) begin
            w_depth_clamped = CNT_WIDTH'(1);
        end else if (cfg_depth > CNT_WIDTH'(MAX_DEPTH)) begin
            w_depth_clamped = CNT_WIDTH'(MAX_DEPTH);
        end
    end

    // A beat accepted in HOLD always opens a new group.
    assign w_first      = (r_state == HOLD) || ((r_state == ACCUM) && (r_count == '0));
    assign w_eff_depth  = w_first ? w_depth_clamped : r_depth;
    assign w_eff_bias   = w_first ? cfg_bias_en : r_bias_en;
    assign w_next_count = w_first ? CNT_WIDTH'(1) : (r_count + CNT_WIDTH'(1));
    assign w_beat_next  = (w_next_count != w_eff_depth) ? ACCUM : (w_eff_bias ? BIAS : HOLD);

    assign w_op_man = (r_state == BIAS) ? mbias : mdata_in_0;
    assign w_op_exp = (r_state == BIAS) ? ebias : edata_in_0;

    mxint_align_add #(
        .IN_MAN_WIDTH  (IN_MAN_WIDTH),
        .OUT_MAN_WIDTH (OUT_MAN_WIDTH),
        .IN_EXP_WIDTH  (IN_EXP_WIDTH),
        .BLOCK_SIZE    (BLOCK_SIZE)
    ) u_align_add (
        .i_acc_man (r_acc),
        .i_acc_exp (r_exp),
        .i_op_man  (w_op_man),
        .i_op_exp  (w_op_exp),
        .i_first   (w_first && (r_state != BIAS)),
        .o_sum_man (w_sum_man),
        .o_sum_exp (w_sum_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ACCUM;
            r_count      <= '0;
            r_depth      <= CNT_WIDTH'(1);
            r_bias_en    <= 1'b0;
            r_acc        <= '0;
            r_exp        <= '0;
            r_out_valid  <= 1'b0;
            r_bias_ready <= 1'b0;
        end else if (w_data_hs) begin
            r_acc        <= w_sum_man;
            r_exp        <= w_sum_exp;
            r_count      <= w_next_count;
            r_state      <= w_beat_next;
            r_out_valid  <= (w_beat_next == HOLD);
            r_bias_ready <= (w_beat_next == BIAS);
            if (w_first) begin
                r_depth   <= w_depth_clamped;
                r_bias_en <= cfg_bias_en;
            end
        end else if (w_bias_hs) begin
            r_acc        <= w_sum_man;
            r_exp        <= w_sum_exp;
            r_state      <= HOLD;
            r_bias_ready <= 1'b0;
            r_out_valid  <= 1'b1;
        end else if (w_out_hs) begin
            r_state     <= ACCUM;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mxint_align_accumulator.sv
// Directed bench for mxint_align_accumulator with 8-bit mantissas, 2 lanes, depth up to 4.
module tb_mxint_align_accumulator;

    localparam int unsigned IW = 8;
    localparam int unsigned EW = 4;
    localparam int unsigned BS = 2;
    localparam int unsigned MD = 4;
    localparam int unsigned OW = 11;
    localparam int unsigned CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     cfg_depth;
    logic              cfg_bias_en;
    logic [BS*IW-1:0]  mdata_in_0;
    logic [EW-1:0]     edata_in_0;
    logic              data_in_0_valid;
    logic              data_in_0_ready;
    logic [BS*IW-1:0]  mbias;
    logic [EW-1:0]     ebias;
    logic              bias_valid;
    logic              bias_ready;
    logic [BS*OW-1:0]  mdata_out_0;
    logic [EW-1:0]     edata_out_0;
    logic              data_out_0_valid;
    logic              data_out_0_ready;
    logic [CW-1:0]     accum_count;

    int total = 0;
    int bad   = 0;

    mxint_align_accumulator #(
        .IN_MAN_WIDTH (IW),
        .IN_EXP_WIDTH (EW),
        .BLOCK_SIZE   (BS),
        .MAX_DEPTH    (MD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_depth        (cfg_depth),
        .cfg_bias_en      (cfg_bias_en),
        .mdata_in_0       (mdata_in_0),
        .edata_in_0       (edata_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .mbias            (mbias),
        .ebias            (ebias),
        .bias_valid       (bias_valid),
        .bias_ready       (bias_ready),
        .mdata_out_0      (mdata_out_0),
        .edata_out_0      (edata_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .accum_count      (accum_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BS*OW-1:0] outm(input int a0, input int a1);
        return {OW'(a1), OW'(a0)};
    endfunction

    task automatic put_data(input int a0, input int a1, input int e);
        mdata_in_0      = {IW'(a1), IW'(a0)};
        edata_in_0      = EW'(e);
        data_in_0_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two-beat group; leaves the bench in HOLD with no data offered.
    task automatic group2(input int a0, input int a1, input int ea,
                          input int b0, input int b1, input int eb);
        cfg_depth   = CW'(2);
        cfg_bias_en = 1'b0;
        put_data(a0, a1, ea);
        step();
        put_data(b0, b1, eb);
        step();
        data_in_0_valid = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        rst              = 1'b1;
        cfg_depth        = CW'($urandom);
        cfg_bias_en      = 1'($urandom);
        mdata_in_0       = 16'($urandom);
        edata_in_0       = EW'($urandom);
        data_in_0_valid  = 1'($urandom);
        mbias            = 16'($urandom);
        ebias            = EW'($urandom);
        bias_valid       = 1'($urandom);
        data_out_0_ready = 1'($urandom);
        step();
        step();
        chk("rst_valid", 32'(data_out_0_valid), 32'(0));
        chk("rst_bias_ready", 32'(bias_ready), 32'(0));
        chk("rst_count", 32'(accum_count), 32'(0));
        chk("rst_man", 32'(mdata_out_0), 32'(0));
        chk("rst_exp", 32'(edata_out_0), 32'(0));
        rst              = 1'b0;
        data_in_0_valid  = 1'b0;
        bias_valid       = 1'b0;
        data_out_0_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(data_in_0_ready), 32'(1));

        // Plain sum
        cfg_depth   = CW'(2);
        cfg_bias_en = 1'b0;
        put_data(10, -4, 3);
        step();
        chk("sum_cnt1", 32'(accum_count), 32'(1));
        chk("sum_valid_early", 32'(data_out_0_valid), 32'(0));
        put_data(20, 8, 3);
        step();
        data_in_0_valid = 1'b0;
        chk("sum_valid", 32'(data_out_0_valid), 32'(1));
        chk("sum_man", 32'(mdata_out_0), 32'(outm(30, 4)));
        chk("sum_exp", 32'(edata_out_0), 32'(3));
        chk("sum_cnt2", 32'(accum_count), 32'(2));
        step();
        chk("pop_valid", 32'(data_out_0_valid), 32'(0));
        chk("pop_cnt", 32'(accum_count), 32'(0));

        // Alignment
        group2(64, -64, 2, 2, 2, 4);
        chk("align_man", 32'(mdata_out_0), 32'(outm(18, -14)));
        chk("align_exp", 32'(edata_out_0), 32'(4));
        step();
        group2(2, 2, 4, 64, -64, 2);
        chk("align_rev_man", 32'(mdata_out_0), 32'(outm(18, -14)));
        chk("align_rev_exp", 32'(edata_out_0), 32'(4));
        step();
        group2(-1, 1, 0, 0, 0, 15);
        chk("align_far_man", 32'(mdata_out_0), 32'(outm(-1, 0)));
        chk("align_far_exp", 32'(edata_out_0), 32'(15));
        step();

        // Bias, with bias offered early
        cfg_depth   = CW'(1);
        cfg_bias_en = 1'b1;
        mbias       = {8'(-3), 8'(3)};
        ebias       = EW'(1);
        bias_valid  = 1'b1;
        step();
        chk("bias_early_ready", 32'(bias_ready), 32'(0));
        chk("bias_early_cnt", 32'(accum_count), 32'(0));
        chk("bias_early_valid", 32'(data_out_0_valid), 32'(0));
        put_data(5, 5, 1);
        step();
        data_in_0_valid = 1'b1;
        #1;
        chk("bias_state_ready", 32'(bias_ready), 32'(1));
        chk("bias_in_ready", 32'(data_in_0_ready), 32'(0));
        chk("bias_state_valid", 32'(data_out_0_valid), 32'(0));
        data_in_0_valid = 1'b0;
        step();
        bias_valid = 1'b0;
        chk("bias_valid", 32'(data_out_0_valid), 32'(1));
        chk("bias_man", 32'(mdata_out_0), 32'(outm(8, 2)));
        chk("bias_exp", 32'(edata_out_0), 32'(1));
        chk("bias_ready_hold", 32'(bias_ready), 32'(0));
        step();

        // Backpressure then overlapped handshakes
        data_out_0_ready = 1'b0;
        cfg_depth        = CW'(1);
        cfg_bias_en      = 1'b0;
        put_data(7, -9, 5);
        step();
        cfg_depth = CW'(2);
        put_data(1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_man", 32'(mdata_out_0), 32'(outm(7, -9)));
            chk("bp_exp", 32'(edata_out_0), 32'(5));
            chk("bp_in_ready", 32'(data_in_0_ready), 32'(0));
            step();
        end
        chk("bp_valid", 32'(data_out_0_valid), 32'(1));
        data_out_0_ready = 1'b1;
        #1;
        chk("ov_in_ready", 32'(data_in_0_ready), 32'(1));
        step();
        chk("ov_cnt", 32'(accum_count), 32'(1));
        chk("ov_valid", 32'(data_out_0_valid), 32'(0));
        put_data(3, 4, 0);
        step();
        data_in_0_valid = 1'b0;
        chk("ov_man", 32'(mdata_out_0), 32'(outm(4, 6)));
        chk("ov_valid2", 32'(data_out_0_valid), 32'(1));
        step();

        // Full depth plus bias at max magnitude; config change mid-group ignored
        cfg_depth   = CW'(4);
        cfg_bias_en = 1'b1;
        mbias       = {8'(127), 8'(127)};
        ebias       = EW'(0);
        put_data(127, 127, 0);
        step();
        cfg_depth   = CW'(1);
        cfg_bias_en = 1'b0;
        step();
        chk("mid_cnt", 32'(accum_count), 32'(2));
        chk("mid_valid", 32'(data_out_0_valid), 32'(0));
        chk("mid_bias_ready", 32'(bias_ready), 32'(0));
        step();
        step();
        data_in_0_valid = 1'b0;
        chk("max_cnt", 32'(accum_count), 32'(4));
        chk("max_bias_ready", 32'(bias_ready), 32'(1));
        bias_valid = 1'b1;
        step();
        bias_valid = 1'b0;
        chk("max_man", 32'(mdata_out_0), 32'(outm(635, 635)));
        chk("max_valid", 32'(data_out_0_valid), 32'(1));
        step();

        // Depth 0 behaves as 1
        cfg_depth = CW'(0);
        put_data(1, -1, 2);
        step();
        data_in_0_valid = 1'b0;
        chk("d0_valid", 32'(data_out_0_valid), 32'(1));
        chk("d0_cnt", 32'(accum_count), 32'(1));
        chk("d0_man", 32'(mdata_out_0), 32'(outm(1, -1)));
        step();

        // Depth 7 clamps to 4
        cfg_depth = CW'(7);
        put_data(1, 1, 0);
        step();
        step();
        step();
        chk("d7_cnt3", 32'(accum_count), 32'(3));
        chk("d7_valid3", 32'(data_out_0_valid), 32'(0));
        step();
        data_in_0_valid = 1'b0;
        chk("d7_valid", 32'(data_out_0_valid), 32'(1));
        chk("d7_man", 32'(mdata_out_0), 32'(outm(4, 4)));
        step();

        // Reset mid-group discards partial state
        cfg_depth = CW'(2);
        put_data(9, 9, 3);
        step();
        data_in_0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_cnt", 32'(accum_count), 32'(0));
        chk("mrst_man", 32'(mdata_out_0), 32'(0));
        chk("mrst_exp", 32'(edata_out_0), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mxint_align_accumulator.md
Name: mxint_align_accumulator

Overview:
- Streaming accumulator for MXINT blocks. Each block is BLOCK_SIZE signed mantissas sharing one exponent.
- Sums a run-time-configurable number of blocks, then optionally adds one bias block.
- Uses a bounded-width accumulator aligned to the running maximum exponent. It does not use a full-dynamic-range lossless register.
- Sits between the dot-product array and mxint_cast inside the linear layers. It replaces fixed-depth, compile-time-bias accumulation.

Parameters:
- IN_MAN_WIDTH, 16: signed mantissa width of data and bias inputs.
- IN_EXP_WIDTH, 4: unsigned exponent width. The same encoding is used for data, bias and output.
- BLOCK_SIZE, 4: number of mantissas per block.
- MAX_DEPTH, 16: largest legal cfg_depth.
- OUT_MAN_WIDTH, IN_MAN_WIDTH+$clog2(MAX_DEPTH+1): derived output mantissa width.
- CNT_WIDTH, $clog2(MAX_DEPTH+1): derived counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_depth  in  CNT_WIDTH  number of data blocks per group.
- cfg_bias_en  in  1  add one bias block per group.
- mdata_in_0  in  IN_MAN_WIDTH x BLOCK_SIZE  data mantissas.
- edata_in_0  in  IN_EXP_WIDTH  data exponent.
- data_in_0_valid  in  1  data valid.
- data_in_0_ready  out  1  data ready.
- mbias  in  IN_MAN_WIDTH x BLOCK_SIZE  bias mantissas.
- ebias  in  IN_EXP_WIDTH  bias exponent.
- bias_valid  in  1  bias valid.
- bias_ready  out  1  bias ready.
- mdata_out_0  out  OUT_MAN_WIDTH x BLOCK_SIZE  result mantissas.
- edata_out_0  out  IN_EXP_WIDTH  result exponent.
- data_out_0_valid  out  1  result valid.
- data_out_0_ready  in  1  result ready.
- accum_count  out  CNT_WIDTH  data blocks accepted in the current group.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State ACCUM, accum_count=0.
  - Accumulator mantissas and exponent = 0.
  - data_out_0_valid=0, data_in_0_ready=1, bias_ready=0.
  - Reset mid-group discards all partial state. A pending output is dropped.
- Configuration latching:
  - cfg_depth and cfg_bias_en are sampled only on the first data handshake of a group (accum_count==0).
  - Changes during a group are ignored.
  - cfg_depth=0 is treated as 1. cfg_depth>MAX_DEPTH is clamped to MAX_DEPTH.
- State ACCUM:
  - data_in_0_ready=1, bias_ready=0.
  - Each handshake updates the accumulator and increments accum_count.
  - First beat of a group: acc = sign-extended mantissas, exp = edata_in_0.
  - On the beat that brings the count to the latched depth: go to BIAS if bias is enabled, else to HOLD.
- State BIAS:
  - data_in_0_ready=0, bias_ready=1.
  - A bias handshake performs an aligned add, then goes to HOLD.
  - bias_valid asserted outside BIAS is ignored and not consumed.
- State HOLD:
  - data_out_0_valid=1. mdata_out_0 and edata_out_0 show the accumulator and are held stable until the handshake.
  - bias_ready=0. data_in_0_ready = data_out_0_ready.
  - On output handshake without a data handshake: go to ACCUM with count 0.
  - On simultaneous output and data handshake: the new beat loads as a first beat (new config latched), accum_count=1, state ACCUM.
  - If the latched depth is 1 and bias is disabled, the simultaneous beat sends the state straight back to HOLD.
- Aligned add (per lane, shared exponent):
  - d = |e_in - e_acc|, new exp = max(e_in, e_acc).
  - If e_in > e_acc: acc is arithmetically shifted right by d, then the sign-extended input is added.
  - Otherwise: the input is arithmetically shifted right by d and added to acc.
  - Shifts truncate toward -inf.
  - If d >= OUT_MAN_WIDTH, the shifted operand becomes its sign fill (0 or -1).
  - The width bound holds for up to MAX_DEPTH+1 terms, so no overflow is possible and no saturation logic is needed.
- Latency and throughput:
  - data_out_0_valid rises the cycle after the final data or bias handshake.
  - Throughput is one block per cycle in ACCUM.
  - Back-to-back groups lose no cycle when data_out_0_ready=1.

Decomposition:
- Package mxint_acc_pkg: state enum (ACCUM, BIAS, HOLD) and a width-helper function for OUT_MAN_WIDTH/CNT_WIDTH.
- Sub-module mxint_align_add:
  - Combinational, BLOCK_SIZE lanes.
  - Inputs: acc mantissas/exponent, operand mantissas/exponent, first flag.
  - Outputs: summed mantissas, new exponent.
  - Instantiated once; the operand is muxed between data and bias by state.

Test Plan:
(All scenarios use IN_MAN_WIDTH=8, IN_EXP_WIDTH=4, BLOCK_SIZE=2, MAX_DEPTH=4, so OUT_MAN_WIDTH=11.)
1. Reset: rst high for 2 cycles with random inputs -> valid=0, data_in_0_ready=1, bias_ready=0, accum_count=0.
2. Plain sum: depth=2, no bias, inputs ([10,-4],e3) then ([20,8],e3) -> [30,4], e3, valid the cycle after the 2nd beat.
3. Alignment:
   - depth=2, inputs ([64,-64],e2) then ([2,2],e4) -> [18,-14], e4.
   - Reverse order gives the same result.
   - Input ([-1,1],e0) then ([0,0],e15) -> [-1,0], e15.
4. Bias: depth=1, bias_en=1, input ([5,5],e1), bias ([3,-3],e1) -> [8,2], e1.
   - bias_ready low before the data beat.
   - data_in_0_ready low during BIAS.
   - Early bias_valid is not consumed.
5. Backpressure and overlap: hold data_out_0_ready=0 for 3 cycles -> output stable, data_in_0_ready=0. Then ready=1 with a next beat valid -> both handshakes in the same cycle, accum_count=1.
6. Config:
   - depth=4 with all inputs 127,e0, plus bias 127 -> 635 with no wrap.
   - cfg_depth changed mid-group -> ignored.
   - cfg_depth=0 -> group of 1.
   - cfg_depth=7 -> group of 4.
